ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit beside the EX-stage ALU, owning the architectural HI/LO registers.
- Executes mult, multu, div, divu iteratively (one bit per cycle) and serves mfhi, mflo, mthi, mtlo.
- Raises a stall to the hazard logic when an HI/LO-dependent instruction arrives while an operation is in flight.
- Honours the same Flush that the ID/EX register uses.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>= 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
CLOCK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
req  input  1  EX holds an Opcode 0x00 instruction with a muldiv Funct
Funct  input  6  0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
SrcA  input  WIDTH  forwarded rs value (multiplicand / dividend / mthi, mtlo source)
SrcB  input  WIDTH  forwarded rt value (multiplier / divisor)
Flush  input  1  kill the EX instruction and any in-flight operation
stall  output  1  combinational: req high while state != IDLE
busy  output  1  registered: state != IDLE
done  output  1  one-cycle pulse after HI/LO completion write
result  output  WIDTH  combinational: HI for mfhi, LO for mflo, 0 otherwise
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register

Behaviour:
- Reset (async, RESET_N=0): state IDLE, HI=0, LO=0, counter=0, done=0, busy=0. Internal operand/partial registers are cleared.
- States:
  - IDLE: accepts a request.
  - CALC: runs WIDTH iterations.
  - FIX: applies the sign correction and writes HI/LO.
  - Transitions: IDLE -> CALC -> FIX -> IDLE.
- Request handling in IDLE with req=1 and Flush=0:
  - mult/multu/div/divu: latch operands and signedness; counter=WIDTH; go to CALC.
  - mthi: HI<=SrcA next edge, no state change.
  - mtlo: LO<=SrcA next edge, no state change.
  - mfhi/mflo: result driven combinationally, no state change.
  - Unlisted Funct: ignored.
- Signed ops (mult, div): operate on magnitudes |SrcA| and |SrcB|; the sign is fixed in FIX.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Multiply: shift-add, one multiplier bit per CALC cycle. 2*WIDTH-bit product: HI=upper WIDTH bits, LO=lower.
- Divide: restoring, one quotient bit per CALC cycle. LO=quotient, HI=remainder.
- Divide by zero (SrcB=0): completes with normal latency; LO=all ones, HI=SrcA. No exception.
- Signed overflow (most-negative / -1): LO=most-negative (wraps), HI=0.
- CALC decrements counter each cycle; at counter==1 go to FIX.
- FIX: HI/LO written at the FIX->IDLE edge; done=1 for the following cycle only.
- Latency: operation accepted at edge 0; HI/LO updated at edge WIDTH+1; busy high cycles 1..WIDTH+1; done high in cycle WIDTH+2.
- Independent instructions: the pipeline is not stalled while busy; only a muldiv req stalls.
  - The stalled instruction must be held stable by upstream.
  - It is accepted on the first edge with state==IDLE.
  - mfhi arriving in the FIX cycle stalls one cycle and then reads the new HI.
- Flush=1:
  - In IDLE: the current req is ignored entirely; no mthi/mtlo write.
  - In CALC or FIX: next edge returns to IDLE; HI/LO keep their old values; done is not pulsed.
  - Flush has priority over completion in FIX.
- stall is forced 0 when Flush=1.
- Reset mid-operation: immediate return to reset values; no partial HI/LO write.

Test Plan:
- WIDTH=32, mult SrcA=0xFFFFFFFE (-2), SrcB=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA at edge 33; done high for exactly 1 cycle in cycle 34.
- multu SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
- div SrcA=-7, SrcB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/0 -> LO=0xFFFFFFFF, HI=7.
- mult issued, then mflo req 5 cycles later -> stall=1 until state IDLE; result then equals the new LO; mflo in IDLE -> stall=0, same-cycle result.
- Flush asserted in the 10th CALC cycle of div with HI=0x11, LO=0x22 -> IDLE next edge, HI/LO unchanged, done never asserted.
- mthi 0xABCD with Flush=1 -> HI unchanged. RESET_N pulsed low mid-CALC -> HI=LO=0, busy=0 immediately (asynchronous, no clock edge).

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU; owns the architectural HI/LO registers.
// One multiplier/quotient bit per CALC cycle; the sign correction and HI/LO write happen in FIX.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             req,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand magnitude
  logic [WIDTH-1:0] b_q, b_d;       // divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;   // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;   // product/quotient sign differs
  logic             neg_rem_q, neg_rem_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Operand decode and magnitudes for a request presented in IDLE
  logic             signed_op;
  logic             div_op;
  logic             muldiv_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    signed_op = (Funct == F_MULT) || (Funct == F_DIV);
    div_op    = (Funct == F_DIV)  || (Funct == F_DIVU);
    muldiv_op = (Funct == F_MULT) || (Funct == F_MULTU) || div_op;
    abs_a     = (signed_op && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
    abs_b     = (signed_op && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;
  end

  // One shift-add or restoring-divide step, plus the signed FIX results
  logic [WIDTH:0]   mul_sum;
  logic [W2:0]      div_sh;
  logic [WIDTH:0]   div_trial;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_sh    = {acc_q, 1'b0};
    div_trial = div_sh[W2:WIDTH] - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) acc_step = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
      else                   acc_step = div_sh[W2-1:0];
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_fix = neg_q ? (~acc_q + W2'(1)) : acc_q;
    if (divz_q)     quot_fix = '1;
    else if (neg_q) quot_fix = ~acc_q[WIDTH-1:0] + WIDTH'(1);
    else            quot_fix = acc_q[WIDTH-1:0];
    rem_fix = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
  end

  // Next-state, HI/LO write and operand latch logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !Flush) begin
          if (muldiv_op) begin
            a_d       = abs_a;
            b_d       = abs_b;
            acc_d     = {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
            is_div_d  = div_op;
            neg_d     = signed_op && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_rem_d = signed_op && SrcA[WIDTH-1];
            divz_d    = div_op && (SrcB == '0);
            cnt_d     = CNT_W'(WIDTH);
            state_d   = S_CALC;
          end else if (Funct == F_MTHI) begin
            hi_d = SrcA;
          end else if (Funct == F_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Hazard stall and mfhi/mflo read path
  always_comb begin
    stall = req && !Flush && (state_q != S_IDLE);
    if (req && (Funct == F_MFHI))      result = hi_q;
    else if (req && (Funct == F_MFLO)) result = lo_q;
    else                               result = '0;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
